// File: rtl/fir_axis_pkg.sv
// Shared types and arithmetic helpers for the multi-channel decimating FIR.
// Width derivations, fixed-point round/saturate and coefficient reset values.
package fir_axis_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_ROUND,
      S_OUT
   } state_t;

   localparam int WIDE = 64;
   typedef logic signed [WIDE-1:0] wide_t;

   function automatic int acc_width(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

   function automatic int chan_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

   function automatic wide_t round_half_up(input wide_t acc, input int frac);
      return (acc + (wide_t'(1) <<< (frac - 1))) >>> frac;
   endfunction

   // Rounded result clamped to the signed output range.
   function automatic wide_t round_sat(input wide_t acc, input int frac, input int data_w);
      wide_t y;
      wide_t hi;
      wide_t lo;
      y  = round_half_up(acc, frac);
      hi = (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (data_w - 1));
      if (y > hi) return hi;
      if (y < lo) return lo;
      return y;
   endfunction

   function automatic logic round_overflows(input wide_t acc, input int frac, input int data_w);
      wide_t y;
      wide_t hi;
      wide_t lo;
      y  = round_half_up(acc, frac);
      hi = (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (data_w - 1));
      return (y > hi) || (y < lo);
   endfunction

   // Unity-gain pass-through: tap 0 is just below 1.0, every other tap is zero.
   function automatic wide_t coef_reset(input int idx, input int frac);
      return (idx == 0) ? (wide_t'(1) <<< frac) - wide_t'(1) : wide_t'(0);
   endfunction

endpackage

// File: rtl/fir_delay_ram.sv
// Per-channel sample history, flattened to one array addressed ch*NUM_TAPS+idx.
// One synchronous write port, one combinational read port.
module fir_delay_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the history must read as zero after reset, so this array is built from
   // resettable flops rather than a RAM macro; keep DEPTH small.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fir_axis_mc_decim.sv
// Time-interleaved multi-channel decimating FIR with AXI4-Stream in/out.
// One shared MAC walks NUM_TAPS history words per computed output.
module fir_axis_mc_decim
   import fir_axis_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int COEF_WIDTH   = 16,
   parameter int NUM_TAPS     = 16,
   parameter int NUM_CHANNELS = 2,
   parameter int FACTOR       = 2,
   parameter int FRAC_BITS    = 15
) (
   input  logic                                CLK,
   input  logic                                RESET,
   output logic                                S_AXIS_TREADY,
   input  logic [DATA_WIDTH-1:0]               S_AXIS_TDATA,
   input  logic                                S_AXIS_TLAST,
   input  logic                                S_AXIS_TVALID,
   input  logic                                M_AXIS_TREADY,
   output logic [DATA_WIDTH-1:0]               M_AXIS_TDATA,
   output logic [chan_width(NUM_CHANNELS)-1:0] M_AXIS_TUSER,
   output logic                                M_AXIS_TLAST,
   output logic                                M_AXIS_TVALID,
   input  logic                                COEF_WE,
   input  logic [$clog2(NUM_TAPS)-1:0]         COEF_ADDR,
   input  logic [COEF_WIDTH-1:0]               COEF_DATA,
   output logic                                BUSY,
   output logic                                OVERFLOW,
   output logic                                FRAME_ERR
);

   localparam int CHW    = chan_width(NUM_CHANNELS);
   localparam int IDXW   = $clog2(NUM_TAPS);
   localparam int PHW    = (FACTOR > 1) ? $clog2(FACTOR) : 1;
   localparam int ACC_W  = acc_width(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);
   localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
   localparam int DEPTH  = NUM_CHANNELS * NUM_TAPS;
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t state_q, state_d;

   logic [CHW-1:0]                ch_cnt, ch_q;
   logic [PHW-1:0]                phase;
   logic [IDXW-1:0]               wr_ptr, base_q, step_q, tap_idx;
   logic                          last_q;
   logic signed [ACC_W-1:0]       acc_q;
   logic signed [COEF_WIDTH-1:0]  coef [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0]  rd_sample;
   logic signed [PROD_W-1:0]      prod;
   logic [DATA_WIDTH-1:0]         out_data;
   logic                          overflow_q, frame_err_q;
   logic [AW-1:0]                 waddr, raddr;
   logic                          accept, compute, coef_wr;

   assign S_AXIS_TREADY = (state_q == S_IDLE) && !RESET;
   assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
   assign compute       = (phase == '0) || S_AXIS_TLAST;
   assign coef_wr       = COEF_WE && (state_q == S_IDLE) && (int'(COEF_ADDR) < NUM_TAPS);

   // Walk backwards through the circular history: newest sample first.
   assign tap_idx = IDXW'(int'(base_q) - int'(step_q) + ((base_q < step_q) ? NUM_TAPS : 0));
   assign waddr   = AW'(int'(ch_cnt) * NUM_TAPS + int'(wr_ptr));
   assign raddr   = AW'(int'(ch_q) * NUM_TAPS + int'(tap_idx));
   assign prod    = PROD_W'(coef[step_q]) * PROD_W'(rd_sample);

   fir_delay_ram #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_line (
      .clk   (CLK),
      .rst   (RESET),
      .we    (accept),
      .waddr (waddr),
      .wdata (S_AXIS_TDATA),
      .raddr (raddr),
      .rdata (rd_sample)
   );

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: state_d gets its default before the case so every path assigns it
   // and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept && compute) state_d = S_MAC;
         S_MAC:   if (int'(step_q) == NUM_TAPS - 1) state_d = S_ROUND;
         S_ROUND: state_d = S_OUT;
         S_OUT:   if (M_AXIS_TREADY) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ch_cnt      <= '0;
         phase       <= '0;
         wr_ptr      <= '0;
         ch_q        <= '0;
         base_q      <= '0;
         step_q      <= '0;
         last_q      <= 1'b0;
         acc_q       <= '0;
         out_data    <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < NUM_TAPS; i++) coef[i] <= COEF_WIDTH'(coef_reset(i, FRAC_BITS));
      end else begin
         if (coef_wr) coef[COEF_ADDR] <= COEF_DATA;

         if (accept) begin
            ch_q   <= ch_cnt;
            base_q <= wr_ptr;
            last_q <= S_AXIS_TLAST;
            acc_q  <= '0;
            step_q <= '0;
            if (S_AXIS_TLAST) begin
               if (int'(ch_cnt) != NUM_CHANNELS - 1) frame_err_q <= 1'b1;
               ch_cnt <= '0;
               phase  <= '0;
               wr_ptr <= (int'(wr_ptr) == NUM_TAPS - 1) ? '0 : wr_ptr + IDXW'(1);
            end else if (int'(ch_cnt) == NUM_CHANNELS - 1) begin
               ch_cnt <= '0;
               wr_ptr <= (int'(wr_ptr) == NUM_TAPS - 1) ? '0 : wr_ptr + IDXW'(1);
               phase  <= (int'(phase) == FACTOR - 1) ? '0 : phase + PHW'(1);
            end else begin
               ch_cnt <= ch_cnt + CHW'(1);
            end
         end

         if (state_q == S_MAC) begin
            acc_q  <= acc_q + ACC_W'(prod);
            step_q <= step_q + IDXW'(1);
         end

         if (state_q == S_ROUND) begin
            out_data <= DATA_WIDTH'(round_sat(wide_t'(acc_q), FRAC_BITS, DATA_WIDTH));
            if (round_overflows(wide_t'(acc_q), FRAC_BITS, DATA_WIDTH)) overflow_q <= 1'b1;
         end
      end
   end

   assign M_AXIS_TVALID = (state_q == S_OUT);
   assign M_AXIS_TDATA  = out_data;
   assign M_AXIS_TUSER  = ch_q;
   assign M_AXIS_TLAST  = last_q;
   assign BUSY          = (state_q != S_IDLE);
   assign OVERFLOW      = overflow_q;
   assign FRAME_ERR     = frame_err_q;

endmodule
